// File: rtl/div_issue_sched_if.sv
// Bundles the requester, divider-core and result-buffer signals of div_issue_sched.
// The slave modport is the scheduler's view; master is the surrounding pipeline.
interface div_issue_sched_if #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 6
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [3*NUM_REQ-1:0]     req_funct3;
    logic [32*NUM_REQ-1:0]    req_a;
    logic [32*NUM_REQ-1:0]    req_b;
    logic [TAG_W*NUM_REQ-1:0] req_tag;
    logic [NUM_REQ-1:0]       req_grant;
    logic                     flush;
    logic                     div_start;
    logic [32:0]              div_a;
    logic [32:0]              div_b;
    logic                     div_done;
    logic [32:0]              div_quotient;
    logic [32:0]              div_remainder;
    logic                     div_by_zero;
    logic                     res_valid;
    logic [31:0]              res_value;
    logic [TAG_W-1:0]         res_tag;
    logic                     res_ack;
    logic                     lat_err;

    modport slave (
        input  req_valid, req_funct3, req_a, req_b, req_tag, flush,
        input  div_done, div_quotient, div_remainder, div_by_zero, res_ack,
        output req_grant, div_start, div_a, div_b, res_valid, res_value, res_tag, lat_err
    );

    modport master (
        output req_valid, req_funct3, req_a, req_b, req_tag, flush,
        output div_done, div_quotient, div_remainder, div_by_zero, res_ack,
        input  req_grant, div_start, div_a, div_b, res_valid, res_value, res_tag, lat_err
    );
endinterface

// File: rtl/div_issue_sched.sv
// Shares one fixed-latency sequential divider among NUM_REQ requesters: round-robin
// issue, RISC-V divide corner-case fix-up, single-entry result buffer and flush/drain.
module div_issue_sched #(
    parameter int NUM_REQ     = 2,
    parameter int DIV_LATENCY = 33,
    parameter int TAG_W       = 6
) (
    input logic               clk,
    input logic               rst_n,
    div_issue_sched_if.slave  bus
);
    localparam int              PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [7:0]       LAT_CNT  = 8'(DIV_LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DRAIN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [7:0]         r_cnt;
    logic               r_lat_err;
    logic [31:0]        r_res_value;
    logic [TAG_W-1:0]   r_res_tag;
    logic [1:0]         r_op;
    logic [TAG_W-1:0]   r_tag;
    logic [31:0]        r_a;
    logic [31:0]        r_b;

    logic               w_found;
    logic [PTR_W-1:0]   w_gnt_idx;
    logic               w_slot_free;
    logic               w_issue;
    logic [2:0]         w_f3;
    logic [31:0]        w_a;
    logic [31:0]        w_b;
    logic [TAG_W-1:0]   w_tag;
    logic               w_ovf;
    logic [31:0]        w_result;
    logic               w_unused_ok;

    // Round-robin pick: first valid requester at or after r_rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(r_rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!w_found && bus.req_valid[idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = PTR_W'(idx);
            end
        end
    end

    assign w_f3  = bus.req_funct3[int'(w_gnt_idx)*3 +: 3];
    assign w_a   = bus.req_a[int'(w_gnt_idx)*32 +: 32];
    assign w_b   = bus.req_b[int'(w_gnt_idx)*32 +: 32];
    assign w_tag = bus.req_tag[int'(w_gnt_idx)*TAG_W +: TAG_W];

    assign w_slot_free = (r_state == S_IDLE) || ((r_state == S_HOLD) && bus.res_ack);
    assign w_issue     = rst_n && !bus.flush && w_slot_free && w_found;

    // NOTE: every output of an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        bus.req_grant = '0;
        bus.div_start = 1'b0;
        bus.div_a     = {(w_f3[0] ? 1'b0 : w_a[31]), w_a};
        bus.div_b     = {(w_f3[0] ? 1'b0 : w_b[31]), w_b};
        if (w_issue) begin
            bus.req_grant[w_gnt_idx] = 1'b1;
            bus.div_start            = 1'b1;
        end
        case (r_state)
            S_IDLE:  if (w_issue) w_state_nxt = S_RUN;
            S_RUN: begin
                // The core cannot abort; a flushed op must be drained unless it ends now.
                if (bus.flush)         w_state_nxt = bus.div_done ? S_IDLE : S_DRAIN;
                else if (bus.div_done) w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (bus.flush)        w_state_nxt = S_IDLE;
                else if (bus.res_ack) w_state_nxt = w_issue ? S_RUN : S_IDLE;
            end
            S_DRAIN: if (bus.div_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_ovf = (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);

    always_comb begin
        w_result = bus.div_quotient[31:0];
        case (r_op)
            2'b00: begin
                if (bus.div_by_zero) w_result = 32'hFFFF_FFFF;
                else if (w_ovf)      w_result = 32'h8000_0000;
            end
            2'b01: if (bus.div_by_zero) w_result = 32'hFFFF_FFFF;
            2'b10: begin
                if (bus.div_by_zero) w_result = r_a;
                else if (w_ovf)      w_result = 32'h0;
                else                 w_result = bus.div_remainder[31:0];
            end
            default: w_result = bus.div_by_zero ? r_a : bus.div_remainder[31:0];
        endcase
    end

    // NOTE: reset is synchronous; operand latches are cleared too so post-reset state is fully known.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_cnt       <= '0;
            r_lat_err   <= 1'b0;
            r_res_value <= '0;
            r_res_tag   <= '0;
            r_op        <= '0;
            r_tag       <= '0;
            r_a         <= '0;
            r_b         <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_rr_ptr <= (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + 1'b1;
                r_cnt    <= 8'd1;
                r_op     <= w_f3[1:0];
                r_tag    <= w_tag;
                r_a      <= w_a;
                r_b      <= w_b;
            end else if ((r_state == S_RUN) && (r_cnt != 8'hFF)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_state == S_RUN) && bus.div_done && !bus.flush) begin
                r_res_value <= w_result;
                r_res_tag   <= r_tag;
                if (r_cnt != LAT_CNT) r_lat_err <= 1'b1;
            end
        end
    end

    assign bus.res_valid = (r_state == S_HOLD);
    assign bus.res_value = r_res_value;
    assign bus.res_tag   = r_res_tag;
    assign bus.lat_err   = r_lat_err;

    // funct3[2] and the 33rd result bits carry no information for the final result.
    assign w_unused_ok = ^{bus.req_funct3, bus.div_quotient[32], bus.div_remainder[32]};
endmodule

// File: tb/tb_div_issue_sched.sv
// Self-checking bench for div_issue_sched: stub divider with programmable latency,
// RISC-V divide reference model, directed corner cases plus randomized operations.
module tb_div_issue_sched;
    localparam int NUM_REQ     = 2;
    localparam int DIV_LATENCY = 33;
    localparam int TAG_W       = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_issue_sched_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

    div_issue_sched #(
        .NUM_REQ(NUM_REQ), .DIV_LATENCY(DIV_LATENCY), .TAG_W(TAG_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int n_cmp    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int last_gnt = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Stub divider: captures operands on div_start, raises div_done stub_lat cycles later.
    logic        stub_done  = 1'b0;
    logic        spur_done  = 1'b0;
    bit          stub_busy  = 1'b0;
    int          stub_cnt   = 0;
    int          stub_lat   = DIV_LATENCY;
    logic [32:0] s_a        = '0;
    logic [32:0] s_b        = '0;

    assign bus.div_done = stub_done | spur_done;

    function automatic logic [32:0] raw_q(input logic [32:0] a, input logic [32:0] b);
        longint ea, eb, q;
        ea = longint'($signed(a));
        eb = longint'($signed(b));
        if (eb == 0) return 33'h0DEAD_BEEF;
        q = ea / eb;
        return q[32:0];
    endfunction

    function automatic logic [32:0] raw_r(input logic [32:0] a, input logic [32:0] b);
        longint ea, eb, r;
        ea = longint'($signed(a));
        eb = longint'($signed(b));
        if (eb == 0) return 33'h0CAFE_F00D;
        r = ea % eb;
        return r[32:0];
    endfunction

    initial begin
        bus.div_quotient  = '0;
        bus.div_remainder = '0;
        bus.div_by_zero   = 1'b0;
    end

    always @(negedge clk) begin
        stub_done <= 1'b0;
        if (!rst_n) begin
            stub_busy <= 1'b0;
        end else if (bus.div_start) begin
            stub_busy <= 1'b1;
            stub_cnt  <= 0;
            s_a       <= bus.div_a;
            s_b       <= bus.div_b;
        end else if (stub_busy) begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt + 1 == stub_lat) begin
                stub_done         <= 1'b1;
                stub_busy         <= 1'b0;
                bus.div_quotient  <= raw_q(s_a, s_b);
                bus.div_remainder <= raw_r(s_a, s_b);
                bus.div_by_zero   <= (s_b == 33'h0);
            end
        end
    end

    // RISC-V M-extension result rules, straight from the ISA definition.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        r  = 0;
        case (op)
            2'b00: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                r = sa / sb;
            end
            2'b01: begin
                if (b == 0) return 32'hFFFF_FFFF;
                r = ua / ub;
            end
            2'b10: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                r = sa % sb;
            end
            default: begin
                if (b == 0) return a;
                r = ua % ub;
            end
        endcase
        return r[31:0];
    endfunction

    function automatic logic [32:0] ext(input logic is_unsigned, input logic [31:0] v);
        return is_unsigned ? {1'b0, v} : {v[31], v};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_pt();
        @(posedge clk);
        #1;
    endtask

    task automatic obs_pt();
        @(negedge clk);
    endtask

    task automatic set_req(input int idx, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAG_W-1:0] tag);
        bus.req_valid[idx]             = 1'b1;
        bus.req_funct3[idx*3 +: 3]     = f3;
        bus.req_a[idx*32 +: 32]        = a;
        bus.req_b[idx*32 +: 32]        = b;
        bus.req_tag[idx*TAG_W +: TAG_W] = tag;
    endtask

    // One isolated operation from an idle scheduler: grant, operands, latency, result, ack.
    task automatic run_op(input int idx, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [TAG_W-1:0] tag,
                          input int hold, input int exp_lat);
        int g, waited;
        logic [31:0] exp_v;
        exp_v = ref_result(f3[1:0], a, b);
        drive_pt();
        bus.req_valid = '0;
        set_req(idx, f3, a, b, tag);
        waited = 0;
        obs_pt();
        while (bus.req_grant == '0 && waited < 8) begin
            drive_pt();
            obs_pt();
            waited++;
        end
        check("grant_wait", 64'(waited), 64'(0));
        check("grant", 64'(bus.req_grant), 64'(1) << idx);
        check("div_start", 64'(bus.div_start), 64'(1));
        check("div_a", 64'(bus.div_a), 64'(ext(f3[0], a)));
        check("div_b", 64'(bus.div_b), 64'(ext(f3[0], b)));
        g        = cyc;
        last_gnt = idx;
        drive_pt();
        bus.req_valid = '0;
        waited = 0;
        obs_pt();
        while (!bus.res_valid && waited < 80) begin
            drive_pt();
            obs_pt();
            waited++;
        end
        check("res_latency", 64'(cyc - g), 64'(exp_lat));
        check("res_value", 64'(bus.res_value), 64'(exp_v));
        check("res_tag", 64'(bus.res_tag), 64'(tag));
        for (int h = 0; h < hold; h++) begin
            drive_pt();
            obs_pt();
            check("res_hold_valid", 64'(bus.res_valid), 64'(1));
            check("res_hold_value", 64'(bus.res_value), 64'(exp_v));
        end
        drive_pt();
        bus.res_ack = 1'b1;
        obs_pt();
        drive_pt();
        bus.res_ack = 1'b0;
        obs_pt();
        check("res_valid_clr", 64'(bus.res_valid), 64'(0));
    endtask

    // Both requesters continuously valid, ack on the first res_valid cycle.
    task automatic rr_test();
        logic [2:0]       f3s [2];
        logic [31:0]      as  [2];
        logic [31:0]      bs  [2];
        logic [TAG_W-1:0] ts  [2];
        logic [31:0]      q_v [$];
        logic [TAG_W-1:0] q_t [$];
        int               q_c [$];
        int ng, nr, nxt, budget;
        f3s[0] = 3'b101; as[0] = 32'd100;        bs[0] = 32'd7; ts[0] = 6'd1;
        f3s[1] = 3'b110; as[1] = 32'hFFFF_FF9C;  bs[1] = 32'd7; ts[1] = 6'd2;
        ng = 0; nr = 0; budget = 0;
        nxt = (last_gnt + 1) % NUM_REQ;
        drive_pt();
        set_req(0, f3s[0], as[0], bs[0], ts[0]);
        set_req(1, f3s[1], as[1], bs[1], ts[1]);
        while (nr < 4 && budget < 4 * (DIV_LATENCY + 1) + 40) begin
            obs_pt();
            if (bus.res_valid && bus.res_ack && q_v.size() > 0) begin
                check("rr_latency", 64'(cyc - q_c.pop_front()), 64'(DIV_LATENCY + 1));
                check("rr_value", 64'(bus.res_value), 64'(q_v.pop_front()));
                check("rr_tag", 64'(bus.res_tag), 64'(q_t.pop_front()));
                if (nr < 3) check("rr_b2b_start", 64'(bus.div_start), 64'(1));
                nr++;
            end
            if (bus.req_grant != '0) begin
                check("rr_grant", 64'(bus.req_grant), 64'(1) << nxt);
                q_v.push_back(ref_result(f3s[nxt][1:0], as[nxt], bs[nxt]));
                q_t.push_back(ts[nxt]);
                q_c.push_back(cyc);
                last_gnt = nxt;
                nxt      = (nxt + 1) % NUM_REQ;
                ng++;
            end
            drive_pt();
            bus.res_ack = bus.res_valid;
            if (ng >= 4) bus.req_valid = '0;
            budget++;
        end
        check("rr_results", 64'(nr), 64'(4));
        bus.res_ack   = 1'b0;
        bus.req_valid = '0;
        obs_pt();
    endtask

    // Flush in RUN (drain), flush beating ack in HOLD, flush in IDLE.
    task automatic flush_test();
        int g, g2, bad, waited;
        logic [31:0] exp_v;
        drive_pt();
        bus.req_valid = '0;
        set_req(0, 3'b100, 32'd1000, 32'hFFFF_FFFD, 6'd9);
        obs_pt();
        check("fl_grant0", 64'(bus.req_grant), 64'(1));
        g = cyc;
        drive_pt();
        bus.req_valid = '0;
        set_req(1, 3'b111, 32'd12345, 32'd100, 6'd33);
        while (cyc < g + 10) begin
            obs_pt();
            drive_pt();
        end
        bus.flush = 1'b1;
        obs_pt();
        check("fl_run_no_gnt", 64'(bus.req_grant), 64'(0));
        drive_pt();
        bus.flush = 1'b0;
        bad = 0;
        while (cyc < g + DIV_LATENCY + 1) begin
            obs_pt();
            if (bus.req_grant != '0 || bus.res_valid) bad++;
            drive_pt();
        end
        check("drain_quiet", 64'(bad), 64'(0));
        obs_pt();
        check("drain_exit_gnt", 64'(bus.req_grant), 64'(2));
        g2 = cyc;
        last_gnt = 1;
        exp_v = ref_result(2'b11, 32'd12345, 32'd100);
        drive_pt();
        bus.req_valid = '0;
        waited = 0;
        obs_pt();
        while (!bus.res_valid && waited < 80) begin
            drive_pt();
            obs_pt();
            waited++;
        end
        check("post_drain_lat", 64'(cyc - g2), 64'(DIV_LATENCY + 1));
        check("post_drain_value", 64'(bus.res_value), 64'(exp_v));
        drive_pt();
        bus.flush   = 1'b1;
        bus.res_ack = 1'b1;
        set_req(0, 3'b100, 32'd50, 32'd5, 6'd3);
        obs_pt();
        check("hold_flush_no_gnt", 64'(bus.req_grant), 64'(0));
        drive_pt();
        bus.flush     = 1'b0;
        bus.res_ack   = 1'b0;
        bus.req_valid = '0;
        obs_pt();
        check("hold_flush_clr", 64'(bus.res_valid), 64'(0));
        drive_pt();
        bus.flush = 1'b1;
        set_req(0, 3'b100, 32'd50, 32'd5, 6'd3);
        obs_pt();
        check("idle_flush_no_gnt", 64'(bus.req_grant), 64'(0));
        drive_pt();
        bus.flush     = 1'b0;
        bus.req_valid = '0;
        obs_pt();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rb;
        int          sel;
        bus.req_valid  = '1;
        bus.req_funct3 = {3'b100, 3'b100};
        bus.req_a      = {32'd9, 32'd8};
        bus.req_b      = {32'd3, 32'd2};
        bus.req_tag    = '0;
        bus.flush      = 1'b0;
        bus.res_ack    = 1'b0;

        repeat (3) begin
            drive_pt();
            obs_pt();
            check("rst_grant", 64'(bus.req_grant), 64'(0));
            check("rst_start", 64'(bus.div_start), 64'(0));
        end
        check("rst_res_valid", 64'(bus.res_valid), 64'(0));
        check("rst_res_value", 64'(bus.res_value), 64'(0));
        check("rst_res_tag", 64'(bus.res_tag), 64'(0));
        check("rst_lat_err", 64'(bus.lat_err), 64'(0));

        drive_pt();
        rst_n         = 1'b1;
        bus.req_valid = '0;
        spur_done     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            obs_pt();
            check("spur_res_valid", 64'(bus.res_valid), 64'(0));
            check("spur_lat_err", 64'(bus.lat_err), 64'(0));
            drive_pt();
        end
        spur_done = 1'b0;
        obs_pt();

        run_op(0, 3'b100, 32'hFFFF_FFEC, 32'd3, 6'd5, 0, DIV_LATENCY + 1);
        run_op(1, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 6'd11, 1, DIV_LATENCY + 1);
        run_op(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 6'd12, 0, DIV_LATENCY + 1);
        run_op(1, 3'b101, 32'd7, 32'd0, 6'd13, 0, DIV_LATENCY + 1);
        run_op(0, 3'b111, 32'd7, 32'd0, 6'd14, 2, DIV_LATENCY + 1);
        run_op(1, 3'b100, 32'hFFFF_FFF0, 32'd0, 6'd15, 0, DIV_LATENCY + 1);
        run_op(0, 3'b110, 32'hFFFF_FFF0, 32'd0, 6'd16, 0, DIV_LATENCY + 1);

        for (int n = 0; n < 30; n++) begin
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)      rb = 32'h0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 5));
            run_op($urandom_range(0, NUM_REQ - 1), {1'b1, 2'($urandom_range(0, 3))}, ra, rb,
                   TAG_W'($urandom), $urandom_range(0, 2), DIV_LATENCY + 1);
        end

        rr_test();
        flush_test();

        check("lat_err_clean", 64'(bus.lat_err), 64'(0));
        stub_lat = 30;
        run_op(0, 3'b101, 32'd999, 32'd10, 6'd20, 0, 31);
        check("lat_err_set", 64'(bus.lat_err), 64'(1));
        stub_lat = DIV_LATENCY;
        run_op(1, 3'b100, 32'd64, 32'hFFFF_FFFE, 6'd21, 0, DIV_LATENCY + 1);
        check("lat_err_sticky", 64'(bus.lat_err), 64'(1));
        drive_pt();
        rst_n = 1'b0;
        obs_pt();
        drive_pt();
        rst_n    = 1'b1;
        last_gnt = -1;
        obs_pt();
        check("lat_err_rst", 64'(bus.lat_err), 64'(0));
        check("res_valid_rst", 64'(bus.res_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/div_issue_sched.md
Name: div_issue_sched

Overview:
- Controller that shares one sequential 33-bit divider (DW_div_seq-based core, early_start, fixed latency) among NUM_REQ reservation-station requesters.
- Arbitrates round-robin, sequences divider start/complete, and resolves RISC-V DIV/DIVU/REM/REMU corner cases.
- Holds one result in a single-entry output buffer for the CDB arbiter, and supports pipeline flush.
- Sits between the divide reservation stations and the divider core / CDB arbiter.

Parameters:
- NUM_REQ, 2, number of requesters.
- DIV_LATENCY, 33, cycles from div_start to expected div_done.
- TAG_W, 6, ROB/physical-destination tag width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester op valid.
- req_funct3  in  3*NUM_REQ  funct3 per requester (bit2 = 1 for div ops).
- req_a  in  32*NUM_REQ  dividend per requester.
- req_b  in  32*NUM_REQ  divisor per requester.
- req_tag  in  TAG_W*NUM_REQ  destination tag per requester.
- req_grant  out  NUM_REQ  one-hot grant; op consumed this cycle.
- flush  in  1  kill in-flight and buffered op.
- div_start  out  1  start pulse to divider.
- div_a  out  33  extended dividend.
- div_b  out  33  extended divisor.
- div_done  in  1  divider complete.
- div_quotient  in  33  raw quotient.
- div_remainder  in  33  raw remainder.
- div_by_zero  in  1  divider zero flag.
- res_valid  out  1  result buffer full, to CDB arbiter.
- res_value  out  32  final result.
- res_tag  out  TAG_W  result tag.
- res_ack  in  1  CDB arbiter dequeue.
- lat_err  out  1  sticky: div_done not at cycle DIV_LATENCY.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, rr_ptr=0, cycle counter=0, lat_err=0, res_valid=0, res_value=0, res_tag=0. Reset mid-operation abandons all state; the top level resets the divider from the same rst_n.
- Combinational outputs during reset: req_grant=0, div_start=0.
- States:
  - IDLE: no op in flight, buffer empty.
  - RUN: divider busy, cnt counting.
  - HOLD: result buffered, res_valid=1.
  - DRAIN: flushed op still in divider.
- Issue condition: state==IDLE, or state==HOLD with res_ack=1; plus |req_valid and !flush.
- Issue actions (same cycle, combinational):
  - req_grant = first valid requester at or after rr_ptr (wrapping); div_start=1.
  - div_a/div_b = granted operands, sign-extended if funct3[0]=0, zero-extended if funct3[0]=1.
  - Next state RUN, cnt<=1, rr_ptr <= granted index + 1 mod NUM_REQ.
  - Latch funct3[1:0], tag, a, b.
- When not issuing: div_start=0, req_grant=0; div_a/div_b may hold any value.
- RUN:
  - cnt increments, saturating at 2^8-1.
  - On div_done: capture result, go HOLD.
  - If cnt != DIV_LATENCY at capture, set lat_err.
  - div_done in IDLE/HOLD is ignored (divider emits a spurious complete after reset).
- Result select (a = latched dividend, b = latched divisor, ovf = a==32'h80000000 && b==32'hFFFFFFFF):
  - 00 DIV: div_by_zero -> 32'hFFFFFFFF; ovf -> 32'h80000000; else quotient[31:0].
  - 01 DIVU: div_by_zero -> 32'hFFFFFFFF; else quotient[31:0].
  - 10 REM: div_by_zero -> a; ovf -> 0; else remainder[31:0].
  - 11 REMU: div_by_zero -> a; else remainder[31:0].
- HOLD:
  - res_valid=1; res_value and res_tag stable until res_ack.
  - res_ack with no issue -> IDLE.
  - res_ack with issue -> RUN (back-to-back, zero bubble).
- Flush (highest priority, evaluated before issue):
  - IDLE: no grant that cycle.
  - RUN: -> DRAIN. Divider cannot abort; wait for div_done, discard it, go IDLE. No issue while in DRAIN.
  - HOLD: res_valid<=0, -> IDLE.
  - DRAIN: stay.
- Simultaneous flush and res_ack in HOLD: flush wins; no grant that cycle.
- Latency: grant at cycle 0 -> res_valid at cycle DIV_LATENCY+1 (one registered capture).
- Throughput: one op per DIV_LATENCY+1 cycles when res_ack is returned on the first res_valid cycle.

Test Plan:
- Reset then 3 idle cycles with spurious div_done=1 -> res_valid=0, state IDLE, lat_err=0.
- Req0 DIV a=-20 (32'hFFFFFFEC), b=3 -> div_a=33'h1FFFFFFEC; res_value=32'hFFFFFFFA, res_tag=req0 tag, res_valid at cycle 34.
- Req0 and Req1 both valid continuously, res_ack on first res_valid cycle -> grants alternate 0,1,0,1 back-to-back; new div_start on the same cycle as res_ack.
- Corner cases:
  - DIV 32'h80000000 / 32'hFFFFFFFF -> 32'h80000000.
  - REM same operands -> 0.
  - DIVU 7/0 -> 32'hFFFFFFFF.
  - REMU 7/0 -> 7.
- Flush at cnt=10 in RUN -> no res_valid; req_valid held high gets no grant until the cycle after div_done returns (DRAIN -> IDLE).
- Stub divider returns div_done at cycle 30 -> lat_err=1, stays 1 until reset; result still delivered.
